smm_feeder: RTL

SMM_FEEDER -- requirements
Module: smm_feeder

---
 rtl/smm_pkg.sv | 32 +++
 rtl/smm_operand_buf.sv | 72 +++++++
 rtl/smm_feeder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/smm_pkg.sv
// -----------------------------------------------------------------------------
// smm_pkg
// Shared constants and types for the 3x3 systolic matrix-multiply operand
// feeder (smm_feeder) and its operand buffer (smm_operand_buf).
//   BW_DEFAULT   : default operand element width
//   N            : array dimension (3x3)
//   LOAD_BEATS   : beats per job (9 A elements followed by 9 B elements)
//   FEED_WAVES   : skewed waves presented to the array edges
//   FLUSH_CYCLES : zero cycles that drain the 2-deep PU chain
//   state_t      : feeder FSM state encoding
// -----------------------------------------------------------------------------
package smm_pkg;

    localparam int BW_DEFAULT   = 8;
    localparam int N            = 3;
    localparam int LOAD_BEATS   = 2 * N * N;
    localparam int FEED_WAVES   = 2 * N - 1;
    localparam int FLUSH_CYCLES = N;

    // Counter / address widths: beats 0..17, waves 0..4 (flush reuses 0..2).
    localparam int BEAT_W = 5;
    localparam int WAVE_W = 3;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_CLR,
        ST_FEED,
        ST_FLUSH,
        ST_DONE
    } state_t;

endpackage

// File: rtl/smm_operand_buf.sv
// -----------------------------------------------------------------------------
// smm_operand_buf
// 18-entry register file holding one job: entries 0..8 are A (row-major),
// entries 9..17 are the nine B beats in arrival order. Six combinational
// read ports return the skewed operands for a given wave t:
//   a_rd[i] = A[i][t-i] when 0 <= t-i < N, else 0
//   b_rd[j] = B[t-j][j] when 0 <= t-j < N, else 0
// Configuration macro SMM_FEEDER_BCOLMAJ_EN: B beats arrive column-major,
// so B[r][c] lives at entry 9 + c*N + r instead of 9 + r*N + c.
// Ports:
//   clk        : clock
//   we         : write enable
//   waddr      : write index 0..17
//   wdata      : element to write
//   wave       : wave index t used by the read ports
//   a_rd, b_rd : skewed row / column operands
// -----------------------------------------------------------------------------
module smm_operand_buf
    import smm_pkg::*;
#(
    parameter int BW = BW_DEFAULT
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BEAT_W-1:0] waddr,
    input  logic [BW-1:0]     wdata,
    input  logic [WAVE_W-1:0] wave,
    output logic [BW-1:0]     a_rd [N],
    output logic [BW-1:0]     b_rd [N]
);

    logic [BW-1:0] mem_reg [LOAD_BEATS];

    // Contents are never reset: a fresh job always overwrites every entry
    // before it is read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_port
        int                row_off;
        logic [BEAT_W-1:0] a_addr;
        logic [BEAT_W-1:0] b_addr;
        logic [BW-1:0]     a_val;
        logic [BW-1:0]     b_val;

        always_comb begin
            // Distance of this edge position behind the wavefront.
            row_off = int'(wave) - gi;
            a_addr  = '0;
            b_addr  = '0;
            a_val   = '0;
            b_val   = '0;
            if (row_off >= 0 && row_off < N) begin
                a_addr = BEAT_W'(gi * N + row_off);
`ifdef SMM_FEEDER_BCOLMAJ_EN
                b_addr = BEAT_W'(N * N + gi * N + row_off);
`else
                b_addr = BEAT_W'(N * N + row_off * N + gi);
`endif
                a_val  = mem_reg[a_addr];
                b_val  = mem_reg[b_addr];
            end
        end

        assign a_rd[gi] = a_val;
        assign b_rd[gi] = b_val;
    end

endmodule

// File: rtl/smm_feeder.sv
// -----------------------------------------------------------------------------
// smm_feeder
// Loads an 18-beat job (A row-major, then B) over a valid/ready stream and
// feeds the 3x3 systolic array with skewed operands:
//   LOAD (in_ready=1) -> CLR (1, clear pulse) -> FEED (5 waves)
//   -> FLUSH (3 zero cycles) -> DONE (1, done pulse) -> LOAD
// Every output is registered from the next-state value, so outputs line up
// with the state they describe.
// Configuration macro SMM_FEEDER_BCOLMAJ_EN: B beats are column-major
// (handled inside smm_operand_buf).
// Ports:
//   clk      : clock, rising edge
//   rst_n    : synchronous reset, ACTIVE-HIGH despite its name
//   in_valid : operand beat valid
//   in_ready : feeder accepts a beat (LOAD only)
//   in_data  : operand element
//   a_o[0..2]: row operands to the array west edge
//   b_o[0..2]: column operands to the array north edge
//   clear_o  : one-cycle accumulator clear pulse
//   busy_o   : high in CLR, FEED and FLUSH
//   done_o   : one-cycle pulse once the array results are final
// -----------------------------------------------------------------------------
module smm_feeder
    import smm_pkg::*;
#(
    parameter int BW = BW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] in_data,
    output logic [BW-1:0] a_o [N],
    output logic [BW-1:0] b_o [N],
    output logic          clear_o,
    output logic          busy_o,
    output logic          done_o
);

    state_t            state_reg, state_next;
    logic [BEAT_W-1:0] beat_reg, beat_next;
    logic [WAVE_W-1:0] wave_reg, wave_next;

    logic in_ready_reg;
    logic clear_reg;
    logic busy_reg;
    logic done_reg;
    logic accept;
    logic feed_next;

    logic [BW-1:0] a_rd [N];
    logic [BW-1:0] b_rd [N];

    // in_ready_reg is only ever high in LOAD, so it alone qualifies a beat.
    assign accept    = in_valid && in_ready_reg;
    assign feed_next = (state_next == ST_FEED);

    // wave_reg counts FEED waves 0..4 and is reused to count FLUSH 0..2.
    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        wave_next  = wave_reg;
        case (state_reg)
            ST_LOAD: begin
                if (accept) begin
                    if (beat_reg == BEAT_W'(LOAD_BEATS - 1)) begin
                        beat_next  = '0;
                        state_next = ST_CLR;
                    end else begin
                        beat_next = beat_reg + 1'b1;
                    end
                end
            end
            ST_CLR: begin
                wave_next  = '0;
                state_next = ST_FEED;
            end
            ST_FEED: begin
                if (wave_reg == WAVE_W'(FEED_WAVES - 1)) begin
                    wave_next  = '0;
                    state_next = ST_FLUSH;
                end else begin
                    wave_next = wave_reg + 1'b1;
                end
            end
            ST_FLUSH: begin
                if (wave_reg == WAVE_W'(FLUSH_CYCLES - 1)) begin
                    wave_next  = '0;
                    state_next = ST_DONE;
                end else begin
                    wave_next = wave_reg + 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_LOAD;
            end
            default: begin
                beat_next  = '0;
                wave_next  = '0;
                state_next = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_reg    <= ST_LOAD;
            beat_reg     <= '0;
            wave_reg     <= '0;
            in_ready_reg <= 1'b0;
            clear_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            beat_reg     <= beat_next;
            wave_reg     <= wave_next;
            in_ready_reg <= (state_next == ST_LOAD);
            clear_reg    <= (state_next == ST_CLR);
            busy_reg     <= (state_next == ST_CLR) || (state_next == ST_FEED) ||
                            (state_next == ST_FLUSH);
            done_reg     <= (state_next == ST_DONE);
        end
    end

    // Reset wins over a coincident accept: the beat is not written.
    smm_operand_buf #(
        .BW (BW)
    ) u_buf (
        .clk   (clk),
        .we    (accept && !rst_n),
        .waddr (beat_reg),
        .wdata (in_data),
        .wave  (wave_next),
        .a_rd  (a_rd),
        .b_rd  (b_rd)
    );

    // Edge operand registers load the wave about to be presented; zero
    // everywhere outside FEED.
    for (genvar gi = 0; gi < N; gi++) begin : g_edge
        logic [BW-1:0] a_reg;
        logic [BW-1:0] b_reg;

        always_ff @(posedge clk) begin
            if (rst_n) begin
                a_reg <= '0;
                b_reg <= '0;
            end else begin
                a_reg <= feed_next ? a_rd[gi] : '0;
                b_reg <= feed_next ? b_rd[gi] : '0;
            end
        end

        assign a_o[gi] = a_reg;
        assign b_o[gi] = b_reg;
    end

    assign in_ready = in_ready_reg;
    assign clear_o  = clear_reg;
    assign busy_o   = busy_reg;
    assign done_o   = done_reg;

endmodule
